// File: rtl/alu32_pkg.sv
// Shared types and constants for the 32-bit ALU execution stage.
package alu32_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  // Opcode encodings; 8..15 are illegal.
  typedef enum logic [3:0] {
    OpAnd = 4'd0,
    OpOr  = 4'd1,
    OpXor = 4'd2,
    OpAdd = 4'd3,
    OpSub = 4'd4,
    OpSll = 4'd5,
    OpSrl = 4'd6,
    OpSra = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic logic is_shift(logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/add32.sv
// 32-bit adder with carry in and carry out.
module add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

// File: rtl/alu32_comb.sv
// Single-cycle op mux: logic ops, ADD/SUB with carry/overflow, pass-through for zero-amount
// shifts, and illegal-opcode detection.
module alu32_comb
  import alu32_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  output logic [XLEN-1:0] z_o,
  output logic            carry_o,
  output logic            ovf_o,
  output logic            err_o
);

  logic [XLEN-1:0] and_r, or_r, xor_r, sum_r, b_sel;
  logic            is_sub, cout;

  // SUB is x + ~y + 1 so the adder carry is NOT borrow.
  assign is_sub = (op_i == OpSub);
  assign b_sel  = is_sub ? ~y_i : y_i;

  and32 u_and (.a_i(x_i), .b_i(y_i), .y_o(and_r));
  or32  u_or  (.a_i(x_i), .b_i(y_i), .y_o(or_r));
  xor32 u_xor (.a_i(x_i), .b_i(y_i), .y_o(xor_r));
  add32 u_add (.a_i(x_i), .b_i(b_sel), .cin_i(is_sub), .sum_o(sum_r), .cout_o(cout));

  // Select result and flags by opcode.
  always_comb begin
    z_o     = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    err_o   = 1'b0;
    case (op_i)
      OpAnd: z_o = and_r;
      OpOr:  z_o = or_r;
      OpXor: z_o = xor_r;
      OpAdd, OpSub: begin
        z_o     = sum_r;
        carry_o = cout;
        ovf_o   = (x_i[XLEN-1] == b_sel[XLEN-1]) && (sum_r[XLEN-1] != x_i[XLEN-1]);
      end
      // Only reached for a zero shift amount; non-zero amounts go through the iterative path.
      OpSll, OpSrl, OpSra: z_o = x_i;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/and32.sv
// 32-bit bitwise AND.
module and32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/or32.sv
// 32-bit bitwise OR.
module or32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/xor32.sv
// 32-bit bitwise XOR.
module xor32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// File: rtl/alu32_seq_unit.sv
// Sequential ALU stage: valid/ready input, single-cycle logic/arith ops, iterative shifts and
// a result register held until the consumer takes it.
module alu32_seq_unit
  import alu32_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] z,
  output logic            zero,
  output logic            neg,
  output logic            carry,
  output logic            ovf,
  output logic            err
);

  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(SHIFT_STEP);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    z_q, z_d;
  logic               carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
  logic               zero_q, neg_q;

  logic [XLEN-1:0]    comb_z, shifted;
  logic               comb_carry, comb_ovf, comb_err;
  logic [SHAMT_W-1:0] step;
  logic               accept;

  alu32_comb u_comb (
    .op_i    (op),
    .x_i     (x),
    .y_i     (y),
    .z_o     (comb_z),
    .carry_o (comb_carry),
    .ovf_o   (comb_ovf),
    .err_o   (comb_err)
  );

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign z         = z_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // One shift step: min(SHIFT_STEP, remaining) bits in the captured direction.
  always_comb begin
    step = (cnt_q < StepAmt) ? cnt_q : StepAmt;
    case (op_q)
      OpSll:   shifted = work_q << step;
      OpSrl:   shifted = work_q >> step;
      default: shifted = XLEN'($signed(work_q) >>> step);
    endcase
  end

  // Next-state and result-register update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          op_d = op;
          if (is_shift(op) && (y[SHAMT_W-1:0] != '0)) begin
            state_d = StShift;
            work_d  = x;
            cnt_d   = y[SHAMT_W-1:0];
          end else begin
            state_d = StDone;
            z_d     = comb_z;
            carry_d = comb_carry;
            ovf_d   = comb_ovf;
            err_d   = comb_err;
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - step;
        if (cnt_q <= StepAmt) begin
          state_d = StDone;
          z_d     = shifted;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and result registers; zero/neg track the registered z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zero_q  <= (z_d == '0);
      neg_q   <= z_d[XLEN-1];
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu32_seq_unit.sv
// Scoreboard bench for alu32_seq_unit: driver pushes model results, monitor pops on transfer.
module tb_alu32_seq_unit;
  import alu32_pkg::*;

  localparam int unsigned S = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] x = '0, y = '0;
  logic        in_ready, out_valid, zero, neg, carry, ovf, err;
  logic [31:0] z;

  alu32_seq_unit #(.SHIFT_STEP(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] z;
    logic        zero, neg, carry, ovf, err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bit   rand_rdy = 1'b0;
  logic force_rdy = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model from the opcode rules; lat counts cycles from accept edge to result edge.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, sv;
    int     amt;
    logic [32:0] s33;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    e.z = '0; e.carry = 0; e.ovf = 0; e.err = 0; e.lat = 0; e.acc_cyc = 0;
    case (o)
      4'd0: e.z = a & b;
      4'd1: e.z = a | b;
      4'd2: e.z = a ^ b;
      4'd3: begin
        s33 = {1'b0, a} + {1'b0, b};
        e.z = s33[31:0];
        e.carry = s33[32];
        sv = sa + sb;
        e.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd4: begin
        e.z = a - b;
        e.carry = (a >= b);
        sv = sa - sb;
        e.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd5: begin e.z = a << amt; e.lat = (amt + S - 1) / S; end
      4'd6: begin e.z = a >> amt; e.lat = (amt + S - 1) / S; end
      4'd7: begin e.z = $signed(a) >>> amt; e.lat = (amt + S - 1) / S; end
      default: e.err = 1;
    endcase
    e.zero = (e.z == 0);
    e.neg  = e.z[31];
    return e;
  endfunction

  // Monitor: checks the presented result every cycle it is valid, latency on first presentation.
  bit hold_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=out_valid=1 required=no result pending");
        end else begin
          chk("z", z, q[0].z);
          chk("zero", 32'(zero), 32'(q[0].zero));
          chk("neg", 32'(neg), 32'(q[0].neg));
          chk("carry", 32'(carry), 32'(q[0].carry));
          chk("ovf", 32'(ovf), 32'(q[0].ovf));
          chk("err", 32'(err), 32'(q[0].err));
          if (!hold_prev) chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
          if (out_ready) void'(q.pop_front());
        end
      end
      hold_prev = out_valid && !out_ready;
    end
  end

  // Present one request from a fresh cycle and hold it until it is accepted.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    e = model(o, a, b);
    in_valid = 1'b1; op = o; x = a; y = b;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=in_ready=0 required=accept within 300 cycles");
        break;
      end
    end
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); x = $urandom; y = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      k++;
      if (k > 2000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d pending required=0 pending", q.size());
        q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    // Reset behaviour.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_z", z, 32'd0);

    // Directed single-cycle ops.
    force_rdy = 1'b1;
    issue(4'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    issue(4'd3, 32'h7FFF_FFFF, 32'd1);
    issue(4'd4, 32'd0, 32'd1);
    issue(4'd4, 32'd5, 32'd5);
    issue(4'd4, 32'h8000_0000, 32'd1);
    drain();

    // Long arithmetic shift: in_ready stays low until the result appears.
    issue(4'd7, 32'h8000_0000, 32'd31);
    k = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      chk("shift_in_ready", 32'(in_ready), 32'd0);
      k++;
      if (k > 100) begin
        checks++;
        errors++;
        $display("FAIL shift_timeout actual=no result required=result within 100 cycles");
        break;
      end
    end
    drain();
    issue(4'd5, 32'h1234_5678, 32'h0000_0020);
    issue(4'hC, 32'hDEAD_BEEF, 32'h1234_5678);
    drain();

    // Backpressure then back-to-back accept.
    force_rdy = 1'b0;
    out_ready = 1'b0;
    issue(4'd3, 32'hFFFF_FFFF, 32'd2);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    force_rdy = 1'b1;
    out_ready = 1'b1;
    issue(4'd1, 32'hA5A5_0000, 32'h0000_5A5A);
    drain();

    // Reset in the middle of a shift discards it.
    issue(4'd6, 32'hFFFF_FFFF, 32'd20);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_z", z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd2, 32'hFFFF_0000, 32'h00FF_FF00);
    drain();

    // Random legal ops with random consumer backpressure.
    rand_rdy = 1'b1;
    repeat (500) begin
      ro = 4'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      issue(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
